// File: rtl/collision_pkg.sv
// collision_pkg: shared encodings for the collision-search instruction driver
// Holds instruction-select codes, message geometry and driver FSM states.
package collision_pkg;
    localparam int MSG_W = 512;
    localparam int PAIRS = 8;
    typedef enum logic [2:0] {
        CI_BASE    = 3'd0,
        CI_START   = 3'd1,
        CI_RESULT  = 3'd2,
        CI_FOUND   = 3'd3,
        CI_DIGESTS = 3'd4
    } ci_op_e;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_POLL, S_FETCH, S_COUNT, S_RESP
    } state_e;
endpackage

// File: rtl/ci_issue.sv
// ci_issue: one-instruction custom-instruction handshake unit
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/n_i/a_i/b_i request held
// until done_o; ci_start_o/ci_n_o/ci_dataa_o/ci_datab_o/ci_done_i/ci_result_i instruction
// side; done_o/result_o completion of the outstanding request.
module ci_issue
    import collision_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [2:0]  n_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        ci_start_o,
    output logic [2:0]  ci_n_o,
    output logic [31:0] ci_dataa_o,
    output logic [31:0] ci_datab_o,
    input  logic        ci_done_i,
    input  logic [31:0] ci_result_i,
    output logic        done_o,
    output logic [31:0] result_o
);
    logic        busy_q, busy_d;
    logic [2:0]  n_q;
    logic [31:0] a_q, b_q;
    // Start fires only when nothing is outstanding, so the next issue lands the cycle after done.
    assign ci_start_o = req_i & ~busy_q;
    // Done is honoured only for an instruction in flight; stray done pulses are dropped.
    assign done_o     = (ci_start_o | busy_q) & ci_done_i;
    assign result_o   = ci_result_i;
    assign busy_d     = busy_q ? ~ci_done_i : ci_start_o & ~ci_done_i;
    // Operands come straight from the request in the start cycle, then from the held copy.
    assign ci_n_o     = busy_q ? n_q : ci_start_o ? n_i : CI_BASE;
    assign ci_dataa_o = busy_q ? a_q : ci_start_o ? a_i : 32'd0;
    assign ci_datab_o = busy_q ? b_q : ci_start_o ? b_i : 32'd0;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            n_q    <= CI_BASE;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
        end else begin
            busy_q <= busy_d;
            if (ci_start_o) begin
                n_q <= n_i;
                a_q <= a_i;
                b_q <= b_i;
            end
        end
    end
endmodule

// File: rtl/collision_driver.sv
// collision_driver: runs one collision-search job over the custom-instruction interface
// Ports: clk_i/reset_n_i clock and async active-low reset; cmd_* job request (message,
// target); abort_i stops polling; ci_* instruction-side signals; rsp_* valid/ready result.
module collision_driver
    import collision_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned MAX_POLLS     = 0
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [MSG_W-1:0] cmd_message_i,
    input  logic [31:0]      cmd_target_i,
    input  logic             abort_i,
    output logic             ci_clk_en_o,
    output logic             ci_start_o,
    output logic [2:0]       ci_n_o,
    output logic [31:0]      ci_dataa_o,
    output logic [31:0]      ci_datab_o,
    input  logic             ci_done_i,
    input  logic [31:0]      ci_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_found_o,
    output logic [31:0]      rsp_counter_o,
    output logic [31:0]      rsp_digests_o
);
    localparam int WW = $clog2(POLL_INTERVAL + 1);
    state_e           state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [31:0]      target_q, target_d, polls_q, polls_d, polls_inc;
    logic [31:0]      counter_q, counter_d, digests_q, digests_d;
    logic [2:0]       k_q, k_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             abort_q, abort_d, found_q, found_d;
    logic             req, done, abort_now, timeout;
    logic [2:0]       n_req;
    logic [31:0]      a_req, b_req, result;
    logic [8:0]       hi;
    ci_issue u_issue (
        .clk_i      (clk_i),
        .rst_ni     (reset_n_i),
        .req_i      (req),
        .n_i        (n_req),
        .a_i        (a_req),
        .b_i        (b_req),
        .ci_start_o (ci_start_o),
        .ci_n_o     (ci_n_o),
        .ci_dataa_o (ci_dataa_o),
        .ci_datab_o (ci_datab_o),
        .ci_done_i  (ci_done_i),
        .ci_result_i(ci_result_i),
        .done_o     (done),
        .result_o   (result)
    );
    assign ci_clk_en_o   = reset_n_i;
    assign cmd_ready_o   = state_q == S_IDLE;
    assign rsp_valid_o   = state_q == S_RESP;
    assign rsp_found_o   = found_q;
    assign rsp_counter_o = counter_q;
    assign rsp_digests_o = digests_q;
    // Pair k occupies msg[511-64k -: 64], A word first.
    assign hi        = 9'd511 - {k_q, 6'd0};
    assign abort_now = abort_q | abort_i;
    assign polls_inc = &polls_q ? polls_q : polls_q + 32'd1;
    assign timeout   = (MAX_POLLS != 0) && (polls_inc == MAX_POLLS);
    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        target_d  = target_q;
        polls_d   = polls_q;
        counter_d = counter_q;
        digests_d = digests_q;
        k_d       = k_q;
        wait_d    = wait_q;
        abort_d   = abort_q;
        found_d   = found_q;
        req       = 1'b0;
        n_req     = CI_BASE;
        a_req     = 32'd0;
        b_req     = 32'd0;
        case (state_q)
            S_IDLE: if (cmd_valid_i) begin
                msg_d     = cmd_message_i;
                target_d  = cmd_target_i;
                k_d       = 3'd0;
                polls_d   = 32'd0;
                abort_d   = 1'b0;
                found_d   = 1'b0;
                counter_d = 32'd0;
                digests_d = 32'd0;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                req   = 1'b1;
                a_req = msg_q[hi -: 32];
                b_req = msg_q[hi - 9'd32 -: 32];
                if (done) begin
                    k_d     = k_q + 3'd1;
                    state_d = k_q == 3'(PAIRS - 1) ? S_START : S_LOAD;
                end
            end
            S_START: begin
                req   = 1'b1;
                n_req = CI_START;
                a_req = target_q;
                if (done) begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                abort_d = abort_now;
                if (wait_q == WW'(POLL_INTERVAL - 1)) state_d = abort_now ? S_COUNT : S_POLL;
                else wait_d = wait_q + 1'b1;
            end
            S_POLL: begin
                abort_d = abort_now;
                req     = 1'b1;
                n_req   = CI_FOUND;
                if (done) begin
                    polls_d = polls_inc;
                    wait_d  = '0;
                    // A hit wins over both a pending abort and the poll limit.
                    state_d = result[0] ? S_FETCH : (abort_now || timeout) ? S_COUNT : S_WAIT;
                end
            end
            S_FETCH: begin
                req   = 1'b1;
                n_req = CI_RESULT;
                if (done) begin
                    counter_d = result;
                    found_d   = 1'b1;
                    state_d   = S_COUNT;
                end
            end
            S_COUNT: begin
                req   = 1'b1;
                n_req = CI_DIGESTS;
                if (done) begin
                    digests_d = result;
                    state_d   = S_RESP;
                end
            end
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            msg_q     <= '0;
            target_q  <= 32'd0;
            polls_q   <= 32'd0;
            counter_q <= 32'd0;
            digests_q <= 32'd0;
            k_q       <= 3'd0;
            wait_q    <= '0;
            abort_q   <= 1'b0;
            found_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            target_q  <= target_d;
            polls_q   <= polls_d;
            counter_q <= counter_d;
            digests_q <= digests_d;
            k_q       <= k_d;
            wait_q    <= wait_d;
            abort_q   <= abort_d;
            found_q   <= found_d;
        end
    end
endmodule

// File: doc/collision_driver.md
# collision_driver

Hardware initiator for the collision-search custom-instruction interface. It accepts one search job (512-bit base message plus 32-bit target) from a local command port. It then drives the instruction-side signals (`clk_en`, `start`, `dataa`, `datab`, `n`) exactly as the Nios II core would: load the message, start the search, poll for a hit, then fetch the collision counter and digest count. The result is returned on a valid/ready response port, so a search can run without CPU involvement, for example from a DMA/job engine or a self-checking bench harness.

## Interface
- `POLL_INTERVAL`, 16: idle cycles between the completion of one status poll (or of the start-search instruction) and the issue of the next poll; minimum 1.
- `MAX_POLLS`, 0: poll limit before timeout; 0 means unlimited.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_message`  in  512  base message, sampled on accept.
- `cmd_target`  in  32  target value, sampled on accept.
- `abort`  in  1  single-cycle request to stop polling.
- `ci_clk_en`  out  1  instruction clock enable.
- `ci_start`  out  1  one-cycle issue pulse.
- `ci_n`  out  3  instruction select.
- `ci_dataa`  out  32  operand A.
- `ci_datab`  out  32  operand B.
- `ci_done`  in  1  instruction complete; may be high in the same cycle as `ci_start`.
- `ci_result`  in  32  valid while `ci_done` is high.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_found`  out  1  collision found.
- `rsp_counter`  out  32  collision counter; 0 if not found.
- `rsp_digests`  out  32  total digests reported by the searcher.

## Operation
- **States:** IDLE, LOAD, START, WAIT, POLL, FETCH, COUNT, RESP.
- **IDLE:** `cmd_valid & cmd_ready` latches message and target, clears the pair index k and poll count, and moves to LOAD.
- **LOAD:** issues `n=0` for k = 0..7.
  - `dataa = msg[511-64k -: 32]`, `datab = msg[479-64k -: 32]`, MSB-first.
  - k increments on each done; after k=7 completes, go to START.
- **START:** issues `n=1` with `dataa=target`, `datab=0`, then enters WAIT.
- **WAIT:** counts POLL_INTERVAL cycles, then enters POLL.
- **POLL:** issues `n=3` and increments the poll count. On done:
  - `ci_result[0]=1`: go to FETCH.
  - Otherwise, if `MAX_POLLS != 0` and poll count equals MAX_POLLS: timeout, go to COUNT with found=0.
  - Otherwise: go to WAIT.
- **FETCH:** issues `n=2`, latches `rsp_counter`, sets found=1, then enters COUNT.
- **COUNT:** issues `n=4`, latches `rsp_digests`, then enters RESP.
- **RESP:** holds `rsp_valid` until `rsp_ready`, then returns to IDLE.
- **Abort:** `abort` seen in WAIT or POLL sets a sticky abort flag. At the next decision point (end of WAIT, or done of a poll), the flag routes to COUNT with found=0. A poll done reporting found=1 in the same cycle as the abort takes precedence: go to FETCH. `abort` is ignored in all other states.
- **Instruction handshake:**
  - `ci_start` is high for exactly one cycle per instruction.
  - `ci_n`, `ci_dataa` and `ci_datab` are stable from the start cycle through the cycle `ci_done` is sampled high.
  - `ci_done` is sampled in the start cycle and every cycle after it.
  - The next `ci_start` is no earlier than the cycle after done.
  - `ci_done` seen while no instruction is outstanding is ignored.
- **Clock enable:** `ci_clk_en` is 1 whenever `reset_n` is high.

## Timing
- **Reset values:** state IDLE; `cmd_ready` 1 after reset deasserts. `ci_start`, `ci_n`, `ci_dataa`, `ci_datab`, `rsp_*` and `ci_clk_en` are all 0.
- **Reset mid-operation:** returns to IDLE immediately, discards the job, and produces no response.
- **Zero-latency done** (done in the same cycle as start). Accept is cycle 0:
  - LOAD starts in cycles 1–8; the START issue is in cycle 9.
  - The first poll issue is in cycle 10+POLL_INTERVAL.
  - After a hit poll in cycle P, FETCH is at P+1, COUNT at P+2, and `rsp_valid` rises at P+3.
- **Late done:** each cycle of `ci_done` latency adds exactly one cycle to the affected instruction.
- **Response outputs:** registered and stable while `rsp_valid & !rsp_ready`.
- **Back-to-back jobs:** `cmd_ready` rises the cycle after the response handshake.
- **Poll counter:** 32 bits, saturating. The WAIT counter is `$clog2(POLL_INTERVAL+1)` bits.

## Structure
- **Shared package/header** `collision_pkg`, reused by the instruction block:
  - `n` encodings: BASE=0, START=1, RESULT=2, FOUND=3, DIGESTS=4.
  - Message width 512 and pair count 8.
  - State encodings.
- **Sub-module** `ci_issue`: one-instruction handshake unit. It takes a request with n/a/b, generates the start pulse, holds the operands, and returns done plus the result. The FSM in `collision_driver` sequences requests to it.

## Test plan
- **Zero-latency responder model, hit on 3rd poll** (msg = `0x00..3F` byte ramp, target `0x00ABCDEF`, result counter `0x12345678`, digests 999): exactly 8 `n=0` issues with k=0 operands `0x00010203`/`0x04050607`, one `n=1` with `dataa=0x00ABCDEF`, 3 polls spaced POLL_INTERVAL cycles apart, then `rsp_found=1`, `rsp_counter=0x12345678`, `rsp_digests=999`, with `rsp_valid` at P+3.
- **Done delayed 5 cycles on every instruction:** operands are held stable for all 6 cycles, there is never a second `ci_start` while an instruction is outstanding, and total latency grows by 5 per instruction.
- **MAX_POLLS=4, never found:** exactly 4 `n=3` issues, no `n=2`, one `n=4`; response is found=0, counter=0.
- **`abort` pulse in WAIT:** no further polls after the current WAIT; `n=4` is issued; response found=0.
- **`abort` coinciding with a hit poll's done:** FETCH is still issued; found=1.
- **Reset asserted during LOAD k=4, then a new job:** all outputs return to reset values asynchronously; the new job restarts at k=0; no stale response appears. Separately, `rsp_ready` held low for 10 cycles keeps `rsp_*` stable and `cmd_ready` low.
